// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : 640x480@60 VGA timing with pixel-tick enable and 5x image scaling.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33,
   parameter int SCALE  = 5
) (
   input  logic        clk,
   input  logic        resetbutton,
   output logic        pix_tick,
   output logic [9:0]  hcount,
   output logic [9:0]  vcount,
   output logic        display_en,
   output logic [13:0] address,
   output logic        VGA_HSYNC,
   output logic        VGA_VSYNC,
   output logic        frame_start
);

   localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

   localparam logic [9:0]       c_h_last     = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0]       c_v_last     = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0]       c_h_vis      = 10'(H_VIS);
   localparam logic [9:0]       c_v_vis      = 10'(V_VIS);
   localparam logic [9:0]       c_hs_start   = 10'(H_VIS + H_FP);
   localparam logic [9:0]       c_hs_end     = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0]       c_vs_start   = 10'(V_VIS + V_FP);
   localparam logic [9:0]       c_vs_end     = 10'(V_VIS + V_FP + V_SYNC);
   localparam logic [SUB_W-1:0] c_sub_last   = SUB_W'(SCALE - 1);

   logic             pix_en_q;
   logic [9:0]       h_q, h_d, v_q, v_d;
   logic [SUB_W-1:0] hsub_q, hsub_d, vsub_q, vsub_d;
   logic [6:0]       col_q, col_d, row_q, row_d;

   logic [9:0]       hcount_q, vcount_q;
   logic [13:0]      address_q, address_d;
   logic             display_en_q, hsync_q, vsync_q, frame_start_q;
   logic             display_en_d, hsync_d, vsync_d, frame_start_d;

   logic             w_h_last, w_v_last;

   assign w_h_last = (h_q == c_h_last);
   assign w_v_last = (v_q == c_v_last);

   // Counter advance: sub-counters divide position by SCALE without a divider.
   always_comb begin
      h_d    = h_q;
      v_d    = v_q;
      hsub_d = hsub_q;
      vsub_d = vsub_q;
      col_d  = col_q;
      row_d  = row_q;
      if (pix_en_q) begin
         if (w_h_last) begin
            h_d    = '0;
            hsub_d = '0;
            col_d  = '0;
            if (w_v_last) begin
               v_d    = '0;
               vsub_d = '0;
               row_d  = '0;
            end else begin
               v_d = v_q + 10'd1;
               if (v_q < c_v_vis) begin
                  if (vsub_q == c_sub_last) begin
                     vsub_d = '0;
                     row_d  = row_q + 7'd1;
                  end else begin
                     vsub_d = vsub_q + 1'b1;
                  end
               end
            end
         end else begin
            h_d = h_q + 10'd1;
            if (h_q < c_h_vis) begin
               if (hsub_q == c_sub_last) begin
                  hsub_d = '0;
                  col_d  = col_q + 7'd1;
               end else begin
                  hsub_d = hsub_q + 1'b1;
               end
            end
         end
      end
   end

   // Output stage samples the current counters, so everything lags them by one clk.
   always_comb begin
      display_en_d  = (h_q < c_h_vis) && (v_q < c_v_vis);
      address_d     = display_en_d ? {row_q, col_q} : 14'd0;
      hsync_d       = !((h_q >= c_hs_start) && (h_q < c_hs_end));
      vsync_d       = !((v_q >= c_vs_start) && (v_q < c_vs_end));
      // (0,0) persists for two clks; only the first has pix_en low.
      frame_start_d = !pix_en_q && (h_q == 10'd0) && (v_q == 10'd0);
   end

   always_ff @(posedge clk) begin
      if (resetbutton) begin
         pix_en_q      <= 1'b0;
         h_q           <= '0;
         v_q           <= '0;
         hsub_q        <= '0;
         vsub_q        <= '0;
         col_q         <= '0;
         row_q         <= '0;
         hcount_q      <= '0;
         vcount_q      <= '0;
         address_q     <= '0;
         display_en_q  <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         pix_en_q      <= ~pix_en_q;
         h_q           <= h_d;
         v_q           <= v_d;
         hsub_q        <= hsub_d;
         vsub_q        <= vsub_d;
         col_q         <= col_d;
         row_q         <= row_d;
         hcount_q      <= h_q;
         vcount_q      <= v_q;
         address_q     <= address_d;
         display_en_q  <= display_en_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign pix_tick    = pix_en_q;
   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign address     = address_q;
   assign display_en  = display_en_q;
   assign VGA_HSYNC   = hsync_q;
   assign VGA_VSYNC   = vsync_q;
   assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Scoreboard bench; full horizontal timing, shortened vertical frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

   // Horizontal timing at defaults; vertical shortened to 17 lines (frame = 27200 clks).
   localparam int V_VIS = 10, V_FP = 2, V_SYNC = 2, V_BP = 3;

   logic        clk = 1'b0;
   logic        resetbutton = 1'b1;
   logic        pix_tick, display_en, VGA_HSYNC, VGA_VSYNC, frame_start;
   logic [9:0]  hcount, vcount;
   logic [13:0] address;

   always #10 clk = ~clk;

   vga_timing_gen #(
      .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SCALE(5)
   ) u_dut (
      .clk(clk), .resetbutton(resetbutton), .pix_tick(pix_tick),
      .hcount(hcount), .vcount(vcount), .display_en(display_en),
      .address(address), .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC),
      .frame_start(frame_start)
   );

   // n = sample index after the n-th edge since release; n = 0 means a reset edge.
   typedef struct {
      int          n;
      logic [9:0]  h, v;
      logic [13:0] a;
      logic        de, hs, vs, fs, tk;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0, errors = 0;
   int   cyc = -1;
   int   fs_cnt = 0, hs_run = 0, vs_run = 0, de_run = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int n, input int h, input int v, input int a,
                       input logic de, input logic hs, input logic vs,
                       input logic fs, input logic tk);
      exp_t e;
      e.n = n; e.h = 10'(h); e.v = 10'(v); e.a = 14'(a);
      e.de = de; e.hs = hs; e.vs = vs; e.fs = fs; e.tk = tk;
      q.push_back(e);
   endtask

   always @(posedge clk) begin
      if (resetbutton) cyc <= 0;
      else if (cyc >= 0) cyc <= cyc + 1;
   end

   // Monitor: scoreboard pops plus run-length checks on the sync/enable waveforms.
   always @(negedge clk) begin
      if (cyc >= 0) begin
         if (q.size() > 0 && q[0].n == cyc) begin
            mon_e = q.pop_front();
            chk($sformatf("hcount@%0d", mon_e.n), 32'(hcount), 32'(mon_e.h));
            chk($sformatf("vcount@%0d", mon_e.n), 32'(vcount), 32'(mon_e.v));
            chk($sformatf("address@%0d", mon_e.n), 32'(address), 32'(mon_e.a));
            chk($sformatf("display_en@%0d", mon_e.n), 32'(display_en), 32'(mon_e.de));
            chk($sformatf("hsync@%0d", mon_e.n), 32'(VGA_HSYNC), 32'(mon_e.hs));
            chk($sformatf("vsync@%0d", mon_e.n), 32'(VGA_VSYNC), 32'(mon_e.vs));
            chk($sformatf("frame_start@%0d", mon_e.n), 32'(frame_start), 32'(mon_e.fs));
            chk($sformatf("pix_tick@%0d", mon_e.n), 32'(pix_tick), 32'(mon_e.tk));
         end
         if (cyc == 0) begin
            hs_run = 0; vs_run = 0; de_run = 0;
         end else begin
            if (!VGA_HSYNC) hs_run++;
            else if (hs_run != 0) begin chk("hsync_low_width", hs_run, 192); hs_run = 0; end
            if (!VGA_VSYNC) vs_run++;
            else if (vs_run != 0) begin chk("vsync_low_width", vs_run, 3200); vs_run = 0; end
            if (display_en) de_run++;
            else if (de_run != 0) begin chk("display_en_width", de_run, 1280); de_run = 0; end
         end
         if (frame_start === 1'b1) fs_cnt++;
      end
   end

   task automatic wait_drain(input string name, input int budget);
      int k = 0;
      while (q.size() != 0 && k < budget) begin @(negedge clk); k++; end
      if (q.size() != 0) begin
         checks++; errors++;
         $display("FAIL %s: %0d entries left, next n=%0d, cyc=%0d", name, q.size(), q[0].n, cyc);
         q.delete();
      end
   endtask

   task automatic wait_cyc(input string name, input int target, input int budget);
      int k = 0;
      while (cyc != target && k < budget) begin @(negedge clk); k++; end
      if (cyc != target) begin
         checks++; errors++;
         $display("FAIL %s: cyc=%0d expected %0d", name, cyc, target);
      end
   endtask

   initial begin
      // Reset held for two edges, then one frame plus its wrap.
      push(0, 0, 0, 0, 0, 1, 1, 0, 0);
      push(0, 0, 0, 0, 0, 1, 1, 0, 0);
      push(1,     0,   0,   0, 1, 1, 1, 1, 1);
      push(2,     0,   0,   0, 1, 1, 1, 0, 0);
      push(9,     4,   0,   0, 1, 1, 1, 0, 1);
      push(11,    5,   0,   1, 1, 1, 1, 0, 1);
      push(1279,  639, 0, 127, 1, 1, 1, 0, 1);
      push(1281,  640, 0,   0, 0, 1, 1, 0, 1);
      push(1312,  655, 0,   0, 0, 1, 1, 0, 0);
      push(1313,  656, 0,   0, 0, 0, 1, 0, 1);
      push(1504,  751, 0,   0, 0, 0, 1, 0, 0);
      push(1505,  752, 0,   0, 0, 1, 1, 0, 1);
      push(1600,  799, 0,   0, 0, 1, 1, 0, 0);
      push(1601,  0,   1,   0, 1, 1, 1, 0, 1);
      push(8001,  0,   5, 128, 1, 1, 1, 0, 1);
      push(15679, 639, 9, 255, 1, 1, 1, 0, 1);
      push(16001, 0,  10,   0, 0, 1, 1, 0, 1);
      push(19200, 799, 11,  0, 0, 1, 1, 0, 0);
      push(19201, 0,  12,   0, 0, 1, 0, 0, 1);
      push(22400, 799, 13,  0, 0, 1, 0, 0, 0);
      push(22401, 0,  14,   0, 0, 1, 1, 0, 1);
      push(27200, 799, 16,  0, 0, 1, 1, 0, 0);
      push(27201, 0,   0,   0, 1, 1, 1, 1, 1);
      push(27202, 0,   0,   0, 1, 1, 1, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) resetbutton = 1'b0;
      wait_drain("frame_drain", 30000);

      // One-clk reset mid-frame with counters at h=300, v=3.
      wait_cyc("reset_mid_frame_wait", 32600, 8000);
      resetbutton = 1'b1;
      push(0, 0, 0, 0, 0, 1, 1, 0, 0);
      push(1,    0,   0,  0, 1, 1, 1, 1, 1);
      push(601,  300, 0, 60, 1, 1, 1, 0, 1);
      push(1313, 656, 0,  0, 0, 0, 1, 0, 1);
      @(negedge clk) resetbutton = 1'b0;
      wait_drain("mid_frame_drain", 3000);

      // Reset while hsync is low at h=700.
      wait_cyc("reset_in_hsync_wait", 1400, 2000);
      resetbutton = 1'b1;
      push(0, 0, 0, 0, 0, 1, 1, 0, 0);
      push(1,    0,   0, 0, 1, 1, 1, 1, 1);
      push(1312, 655, 0, 0, 0, 1, 1, 0, 0);
      push(1313, 656, 0, 0, 0, 0, 1, 0, 1);
      push(1505, 752, 0, 0, 0, 1, 1, 0, 1);
      @(negedge clk) resetbutton = 1'b0;
      wait_drain("hsync_reset_drain", 3000);

      chk("frame_start_count", fs_cnt, 4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
